// File: rtl/axis_dest_tagger_pkg.sv
// Shared definitions for the AXI-Stream destination tagger.
// Holds the frame FSM state encoding and the statistics counter width.
package axis_dest_tagger_pkg;

    typedef enum logic {
        HEAD = 1'b0,
        BODY = 1'b1
    } state_t;

    localparam int unsigned CNT_WIDTH = 16;

endpackage

// File: rtl/axis_skid_reg.sv
// Registered output stage with one extra skid slot.
// o_ready comes straight from a flop, so the upstream path never sees i_ready combinationally.
module axis_skid_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready
);

    logic             r_out_valid;
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [WIDTH-1:0] r_skid_data;
    logic             w_load;

    // The output register may take a new beat when it is empty or being drained.
    assign w_load  = !r_out_valid || i_ready;
    assign o_ready = !r_skid_valid;
    assign o_valid = r_out_valid;
    assign o_data  = r_out_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_load) begin
            r_out_valid  <= r_skid_valid || i_valid;
            r_skid_valid <= 1'b0;
        end else if (i_valid && !r_skid_valid) begin
            r_skid_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_load) begin
            r_out_data <= r_skid_valid ? r_skid_data : i_data;
        end else if (i_valid && !r_skid_valid) begin
            r_skid_data <= i_data;
        end
    end

endmodule

// File: rtl/axis_dest_tagger.sv
// Tags each AXI-Stream frame with a tdest taken from a field of its first beat.
// Invalid frames are either redirected to DEFAULT_DEST with tuser set, or silently consumed.
module axis_dest_tagger
    import axis_dest_tagger_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
    parameter int DEST_WIDTH   = 2,
    parameter int FIELD_OFFSET = 0,
    parameter int DEST_MAX     = 3,
    parameter int DROP_INVALID = 0,
    parameter int DEFAULT_DEST = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [DEST_WIDTH-1:0] m_axis_tdest,
    output logic                  m_axis_tuser,
    output logic [15:0]           frame_count,
    output logic [15:0]           drop_count
);

    localparam int  PW   = DATA_WIDTH + KEEP_WIDTH + DEST_WIDTH + 2;
    localparam bit  DROP = (DROP_INVALID != 0);

    state_t                r_state;
    logic [DEST_WIDTH-1:0] r_dest;
    logic                  r_inv;
    logic [CNT_WIDTH-1:0]  r_frame_cnt;
    logic [CNT_WIDTH-1:0]  r_drop_cnt;

    logic [DEST_WIDTH-1:0] w_field;
    logic                  w_field_ok;
    logic [DEST_WIDTH-1:0] w_dest;
    logic                  w_inv;
    logic                  w_drop;
    logic                  w_user;
    logic                  w_accept;
    logic                  w_skid_ready;
    logic                  w_skid_valid;
    logic [PW-1:0]         w_in_pay;
    logic [PW-1:0]         w_out_pay;

    // Head beats decide the tag from their own data; body beats reuse the latched decision.
    always_comb begin
        w_field    = s_axis_tdata[FIELD_OFFSET +: DEST_WIDTH];
        w_field_ok = (32'(w_field) <= DEST_MAX);
        if (r_state == HEAD) begin
            w_dest = w_field_ok ? w_field : DEST_WIDTH'(DEFAULT_DEST);
            w_inv  = !w_field_ok;
        end else begin
            w_dest = r_dest;
            w_inv  = r_inv;
        end
        w_drop = DROP && w_inv;
        w_user = w_inv ? 1'b1 : s_axis_tuser;
    end

    // A frame being dropped mid-body never touches the skid buffer, so it can always be consumed.
    assign s_axis_tready = !rst && (w_skid_ready || (r_state == BODY && r_inv && DROP));
    assign w_accept      = s_axis_tvalid && s_axis_tready;
    assign w_in_pay      = {s_axis_tdata, s_axis_tkeep, s_axis_tlast, w_dest, w_user};

    axis_skid_reg #(
        .WIDTH (PW)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_data  (w_in_pay),
        .i_valid (w_accept && !w_drop),
        .o_ready (w_skid_ready),
        .o_data  (w_out_pay),
        .o_valid (w_skid_valid),
        .i_ready (m_axis_tready)
    );

    assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tdest, m_axis_tuser} = w_out_pay;
    assign m_axis_tvalid = w_skid_valid;
    assign frame_count   = r_frame_cnt;
    assign drop_count    = r_drop_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= HEAD;
            r_dest      <= '0;
            r_inv       <= 1'b0;
            r_frame_cnt <= '0;
            r_drop_cnt  <= '0;
        end else if (w_accept) begin
            if (r_state == HEAD) begin
                r_dest <= w_dest;
                r_inv  <= w_inv;
                if (!s_axis_tlast) begin
                    r_state <= BODY;
                end
            end else if (s_axis_tlast) begin
                r_state <= HEAD;
            end
            if (s_axis_tlast) begin
                r_frame_cnt <= r_frame_cnt + CNT_WIDTH'(1);
                if (w_drop) begin
                    r_drop_cnt <= r_drop_cnt + CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule
